// File: rtl/alu_mult_seq_pkg.sv
// Shared constants for the iterative shift-and-add multiplier: ALU opcodes
// understood by the shared yAlu and the controller state encodings.
package alu_mult_seq_pkg;

    typedef logic [2:0] alu_op_t;
    typedef logic [1:0] mult_state_t;

    // Opcodes of the shared ALU.
    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

    // Controller states.
    localparam mult_state_t ST_IDLE = 2'd0;
    localparam mult_state_t ST_RUN  = 2'd1;
    localparam mult_state_t ST_DONE = 2'd2;

    // True when this RUN step is the last one: the counter reached its final
    // bit, or (with early exit) no set multiplier bits remain after the shift.
    function automatic logic run_is_last(input logic cnt_at_last,
                                         input logic rest_zero,
                                         input logic early_exit);
        return cnt_at_last || (early_exit && rest_zero);
    endfunction

endpackage

// File: rtl/alu_mult_seq_if.sv
// Port group of the multiplier: start handshake with operands, result
// handshake, busy flag and the borrowed ALU operand/opcode/result lines.
interface alu_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res;
    logic             busy;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_z;

    // Multiplier side.
    modport slave (
        input  start_valid, a_in, b_in, res_ready, alu_z,
        output start_ready, res_valid, res, busy, alu_a, alu_b, alu_op
    );

    // Parent side: issues operands, consumes results, owns the ALU.
    modport master (
        output start_valid, a_in, b_in, res_ready, alu_z,
        input  start_ready, res_valid, res, busy, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative shift-and-add multiplier. Consumes one multiplier bit per cycle and
// uses the external shared ALU for the accumulate ADD. Returns the low WIDTH
// bits of a*b, valid for both signed and unsigned two's-complement operands.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_mult_seq_if.slave        bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mult_state_t      state_q,  state_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic             start_ready_s;
    logic             start_fire_s;
    logic             rest_zero_s;

    // Ready only in IDLE and never while reset is held.
    assign start_ready_s = (state_q == ST_IDLE) && !reset;
    assign start_fire_s  = bus.start_valid && start_ready_s;
    assign rest_zero_s   = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});

    // Next-state and datapath update for the three controller states.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_fire_s) begin
                    mcand_d  = bus.a_in;
                    mplier_d = bus.b_in;
                    acc_d    = {WIDTH{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    if (EARLY_EXIT && (bus.b_in == {WIDTH{1'b0}})) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // ALU sum wraps mod 2^WIDTH; the carry is intentionally dropped.
                acc_d    = mplier_q[0] ? bus.alu_z : acc_q;
                mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_ONE;
                if (run_is_last(cnt_q == CNT_LAST, rest_zero_s, EARLY_EXIT)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // Result held until consumed; new starts are not looked at here.
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // ALU drive decoded from registered state only, so start_valid never
    // reaches the shared ALU combinationally; outside RUN the ALU sees AND 0,0.
    always_comb begin
        bus.alu_a  = {WIDTH{1'b0}};
        bus.alu_b  = {WIDTH{1'b0}};
        bus.alu_op = ALU_AND;
        if (state_q == ST_RUN) begin
            bus.alu_a  = acc_q;
            bus.alu_b  = mcand_q;
            bus.alu_op = ALU_ADD;
        end else begin
            bus.alu_a  = {WIDTH{1'b0}};
            bus.alu_b  = {WIDTH{1'b0}};
            bus.alu_op = ALU_AND;
        end
    end

    // Result handshake and status decoded from registered state.
    always_comb begin
        bus.res_valid = 1'b0;
        bus.res       = {WIDTH{1'b0}};
        if (state_q == ST_DONE) begin
            bus.res_valid = 1'b1;
            bus.res       = acc_q;
        end else begin
            bus.res_valid = 1'b0;
            bus.res       = {WIDTH{1'b0}};
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.start_ready = start_ready_s;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Randomized self-checking bench for alu_mult_seq with a behavioural model of
// the product, the run length and the per-step partial product.
module tb_alu_mult_seq;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    alu_mult_seq_if #(.WIDTH(W)) bus();

    alu_mult_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_res_m = '0;

    // Shared ALU stand-in (yAlu behaviour).
    always_comb begin
        bus.alu_z = '0;
        case (bus.alu_op)
            3'b000:  bus.alu_z = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_z = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_z = bus.alu_a + bus.alu_b;
            3'b110:  bus.alu_z = bus.alu_a - bus.alu_b;
            3'b111:  bus.alu_z = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            default: bus.alu_z = '0;
        endcase
    end

    function automatic logic [W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[W-1:0];
    endfunction

    function automatic int model_len(input logic [W-1:0] b);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Accumulator after c steps: a times the low c bits of b.
    function automatic logic [W-1:0] model_partial(input logic [W-1:0] a, input logic [W-1:0] b, input int c);
        logic [63:0] m;
        m = (64'd1 << c) - 64'd1;
        return model_prod(a, b & m[W-1:0]);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the bench's expectation.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmp_busy_vs_ready", {31'd0, bus.busy}, {31'd0, !bus.start_ready});
            if (bus.res_valid) check("cmp_res", bus.res, exp_res_m);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input bit pulse, input bit use_lit, input logic [W-1:0] lit);
        int n;
        int k;
        n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("start_ready_wait", {31'd0, bus.start_ready}, 32'd1);
        exp_res_m = model_prod(a, b);
        k = model_len(b);
        bus.a_in = a;
        bus.b_in = b;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n <= W + 2) begin
            check("alu_op_step", {29'd0, bus.alu_op}, (n < k) ? 32'd2 : 32'd0);
            if (n < k) begin
                check("alu_a_step", bus.alu_a, model_partial(a, b, n));
                check("alu_b_step", bus.alu_b, a << n);
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", W'(n), W'(k));
        check("res", bus.res, exp_res_m);
        if (use_lit) check("res_literal", bus.res, lit);
        check("alu_op_done", {29'd0, bus.alu_op}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (pulse) begin
                bus.start_valid = 1'b1;
                bus.a_in = $urandom;
                bus.b_in = $urandom;
            end
            @(posedge clk); #1;
            bus.start_valid = 1'b0;
            check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold_res", bus.res, exp_res_m);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("post_hs_valid", {31'd0, bus.res_valid}, 32'd0);
        check("post_hs_ready", {31'd0, bus.start_ready}, 32'd1);
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.res_ready   = 1'b0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid",   {31'd0, bus.res_valid},   32'd0);
        check("rst_res",         bus.res,                  32'd0);
        check("rst_busy",        {31'd0, bus.busy},        32'd0);
        check("rst_start_ready", {31'd0, bus.start_ready}, 32'd0);
        check("rst_alu_op",      {29'd0, bus.alu_op},      32'd0);
        check("rst_alu_a",       bus.alu_a,                32'd0);
        check("rst_alu_b",       bus.alu_b,                32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, bus.start_ready}, 32'd1);

        // Pin the model with hand-computed values.
        check("model_6x7",    model_prod(32'd6, 32'd7), 32'h0000002A);
        check("model_len_7",  W'(model_len(32'd7)), 32'd3);
        check("model_neg",    model_prod(32'hFFFFFFFD, 32'd5), 32'hFFFFFFF1);

        // Directed cases.
        run_op(32'd6,        32'd7,        0, 1'b0, 1'b1, 32'h0000002A);
        run_op(32'h12345678, 32'd0,        0, 1'b0, 1'b1, 32'h00000000);
        run_op(32'd3,        32'h80000000, 0, 1'b0, 1'b1, 32'h80000000);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 1'b1, 32'h00000001);
        run_op(32'hFFFFFFFD, 32'd5,        0, 1'b0, 1'b1, 32'hFFFFFFF1);
        run_op(32'd9,        32'd9,        5, 1'b1, 1'b1, 32'd81);

        // Reset on the second RUN cycle abandons the operation.
        bus.a_in = 32'd5;
        bus.b_in = 32'hFF;
        bus.start_valid = 1'b1;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_res_valid",   {31'd0, bus.res_valid},   32'd0);
        check("midrst_busy",        {31'd0, bus.busy},        32'd0);
        check("midrst_res",         bus.res,                  32'd0);
        check("midrst_alu_op",      {29'd0, bus.alu_op},      32'd0);
        check("midrst_start_ready", {31'd0, bus.start_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", {31'd0, bus.start_ready}, 32'd1);
        run_op(32'd2, 32'd3, 0, 1'b0, 1'b1, 32'd6);

        // Randomized operations with varied multiplier length and backpressure.
        for (int t = 0; t < 24; t++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
